shutter_actuation_seq: RTL and testbench

//  Per-channel kick-then-hold sequencer for the 4-channel shutter card; sits directly upstream of
//  the shutter PWM stage and drives its duty/phase inputs. Decodes SPI move/release/config commands.
//  On a move it drives a timed high-duty kick pulse, then drops to a holding duty.

---
 rtl/shutter_actuation_seq_pkg.sv | 15 +
 rtl/shutter_chan_fsm.sv | 138 +++++++++++++
 rtl/shutter_actuation_seq.sv | 80 ++++++++
 tb/tb_shutter_actuation_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/shutter_actuation_seq_pkg.sv
// Shared command codes and bus widths for the shutter actuation sequencer.
package shutter_actuation_seq_pkg;

    localparam int unsigned CMD_W  = 16;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 40;
    localparam int unsigned N_CHAN = 4;

    localparam logic [CMD_W-1:0] C_SET_SHUTTER_PULSE_DUTY = 16'h0041;
    localparam logic [CMD_W-1:0] C_SET_SHUTTER_HOLD_DUTY  = 16'h0042;
    localparam logic [CMD_W-1:0] C_SET_SHUTTER_PULSE_TIME = 16'h0043;
    localparam logic [CMD_W-1:0] C_SHUTTER_MOVE           = 16'h0044;
    localparam logic [CMD_W-1:0] C_SHUTTER_RELEASE        = 16'h0045;

endpackage

// File: rtl/shutter_chan_fsm.sv
// One shutter channel: kick pulse, hold duty, dead time on direction reversal.
module shutter_chan_fsm #(
    parameter int unsigned CLK_PER_TICK = 38000,
    parameter int unsigned DUTY_WIDTH   = 12,
    parameter int unsigned TIME_WIDTH   = 16,
    parameter int unsigned DEAD_CYCLES  = 38
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  em_stop,
    input  logic                  wr_pulse_duty,
    input  logic                  wr_hold_duty,
    input  logic                  wr_pulse_time,
    input  logic [DUTY_WIDTH-1:0] cfg_duty,
    input  logic [TIME_WIDTH-1:0] cfg_time,
    input  logic                  move,
    input  logic                  move_dir,
    input  logic                  release_cmd,
    output logic [DUTY_WIDTH-1:0] duty,
    output logic                  phase,
    output logic                  busy
);

    localparam int unsigned PRESC_W = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
    localparam int unsigned DEAD_W  = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES + 1) : 1;
    localparam int unsigned CNT_W   = (TIME_WIDTH > DEAD_W) ? TIME_WIDTH : DEAD_W;
    localparam logic [PRESC_W-1:0] PRESC_LOAD = PRESC_W'(CLK_PER_TICK - 1);
    localparam logic [CNT_W-1:0]   DEAD_LOAD  = CNT_W'(DEAD_CYCLES - 1);
    localparam logic               HAS_DEAD   = (DEAD_CYCLES != 0);

    typedef enum logic [1:0] {S_IDLE, S_DEAD, S_PULSE, S_HOLD} state_t;

    state_t                state;
    logic [DUTY_WIDTH-1:0] pulse_duty_r;
    logic [DUTY_WIDTH-1:0] hold_duty_r;
    logic [TIME_WIDTH-1:0] pulse_time_r;
    logic [PRESC_W-1:0]    presc;
    logic [CNT_W-1:0]      cnt;
    logic                  dir_r;

    state_t                entry_state_c;
    logic [DUTY_WIDTH-1:0] entry_duty_c;
    state_t                end_state_c;
    logic [DUTY_WIDTH-1:0] end_duty_c;

    // Where a pulse start lands: PULSE, or straight to the hold decision for zero ticks.
    always_comb begin
        end_state_c   = S_IDLE;
        end_duty_c    = '0;
        if (hold_duty_r != '0) begin
            end_state_c = S_HOLD;
            end_duty_c  = hold_duty_r;
        end
        entry_state_c = end_state_c;
        entry_duty_c  = end_duty_c;
        if (pulse_time_r != '0) begin
            entry_state_c = S_PULSE;
            entry_duty_c  = pulse_duty_r;
        end
    end

    // Channel sequencer with config registers; stop and release take priority over moves.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            pulse_duty_r <= '0;
            hold_duty_r  <= '0;
            pulse_time_r <= '0;
            presc        <= '0;
            cnt          <= '0;
            dir_r        <= 1'b0;
            duty         <= '0;
            phase        <= 1'b0;
            busy         <= 1'b0;
        end else begin
            if (wr_pulse_duty) pulse_duty_r <= cfg_duty;
            if (wr_hold_duty)  hold_duty_r  <= cfg_duty;
            if (wr_pulse_time) pulse_time_r <= cfg_time;

            if (em_stop || release_cmd) begin
                state <= S_IDLE;
                duty  <= '0;
                busy  <= 1'b0;
            end else if (move) begin
                if (HAS_DEAD && (move_dir != phase) && (duty != '0)) begin
                    state <= S_DEAD;
                    duty  <= '0;
                    busy  <= 1'b1;
                    dir_r <= move_dir;
                    cnt   <= DEAD_LOAD;
                end else begin
                    phase <= move_dir;
                    state <= entry_state_c;
                    duty  <= entry_duty_c;
                    busy  <= (entry_state_c == S_PULSE);
                    cnt   <= CNT_W'(pulse_time_r);
                    presc <= PRESC_LOAD;
                end
            end else begin
                case (state)
                    S_DEAD: begin
                        if (cnt == '0) begin
                            phase <= dir_r;
                            state <= entry_state_c;
                            duty  <= entry_duty_c;
                            busy  <= (entry_state_c == S_PULSE);
                            cnt   <= CNT_W'(pulse_time_r);
                            presc <= PRESC_LOAD;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    S_PULSE: begin
                        if (wr_pulse_duty) duty <= cfg_duty;
                        if (presc == '0) begin
                            presc <= PRESC_LOAD;
                            if (cnt <= CNT_W'(1)) begin
                                cnt   <= '0;
                                state <= end_state_c;
                                duty  <= end_duty_c;
                                busy  <= 1'b0;
                            end else begin
                                cnt <= cnt - CNT_W'(1);
                            end
                        end else begin
                            presc <= presc - PRESC_W'(1);
                        end
                    end
                    S_HOLD: begin
                        if (wr_hold_duty) duty <= cfg_duty;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/shutter_actuation_seq.sv
// Four-channel shutter kick/hold sequencer: SPI command decode feeding per-channel FSMs.
module shutter_actuation_seq
    import shutter_actuation_seq_pkg::*;
#(
    parameter logic [7:0]  DEV_ID       = 8'd0,
    parameter int unsigned CLK_PER_TICK = 38000,
    parameter int unsigned DUTY_WIDTH   = 12,
    parameter int unsigned TIME_WIDTH   = 16,
    parameter int unsigned DEAD_CYCLES  = 38
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CMD_W-1:0]      spi_cmd_r,
    input  logic [ADDR_W-1:0]     spi_addr_r,
    input  logic [DATA_W-1:0]     spi_data_r,
    input  logic                  spi_data_valid_r,
    input  logic                  EM_STOP,
    output logic [DUTY_WIDTH-1:0] duty_1,
    output logic [DUTY_WIDTH-1:0] duty_2,
    output logic [DUTY_WIDTH-1:0] duty_3,
    output logic [DUTY_WIDTH-1:0] duty_4,
    output logic                  phase_1,
    output logic                  phase_2,
    output logic                  phase_3,
    output logic                  phase_4,
    output logic [N_CHAN-1:0]     busy
);

    logic                  hit_c;
    logic [1:0]            cfg_ch_c;
    logic [1:0]            mv_ch_c;
    logic                  unused_data_c;
    logic [DUTY_WIDTH-1:0] duty_a [N_CHAN];
    logic [N_CHAN-1:0]     phase_a;

    assign hit_c         = spi_data_valid_r && (spi_addr_r == DEV_ID);
    assign cfg_ch_c      = spi_data_r[17:16];
    assign mv_ch_c       = spi_data_r[2:1];
    assign unused_data_c = ^spi_data_r[DATA_W-1:18];

    // Per-channel write enables and sequencer instances.
    for (genvar n = 0; n < N_CHAN; n++) begin : g_chan
        logic cfg_sel_c;
        logic mv_sel_c;
        assign cfg_sel_c = hit_c && (cfg_ch_c == 2'(n));
        assign mv_sel_c  = hit_c && (mv_ch_c == 2'(n));

        shutter_chan_fsm #(
            .CLK_PER_TICK (CLK_PER_TICK),
            .DUTY_WIDTH   (DUTY_WIDTH),
            .TIME_WIDTH   (TIME_WIDTH),
            .DEAD_CYCLES  (DEAD_CYCLES)
        ) u_chan (
            .clk           (clk),
            .reset         (reset),
            .em_stop       (EM_STOP),
            .wr_pulse_duty (cfg_sel_c && (spi_cmd_r == C_SET_SHUTTER_PULSE_DUTY)),
            .wr_hold_duty  (cfg_sel_c && (spi_cmd_r == C_SET_SHUTTER_HOLD_DUTY)),
            .wr_pulse_time (cfg_sel_c && (spi_cmd_r == C_SET_SHUTTER_PULSE_TIME)),
            .cfg_duty      (spi_data_r[DUTY_WIDTH-1:0]),
            .cfg_time      (spi_data_r[TIME_WIDTH-1:0]),
            .move          (mv_sel_c && (spi_cmd_r == C_SHUTTER_MOVE)),
            .move_dir      (spi_data_r[0]),
            .release_cmd   (mv_sel_c && (spi_cmd_r == C_SHUTTER_RELEASE)),
            .duty          (duty_a[n]),
            .phase         (phase_a[n]),
            .busy          (busy[n])
        );
    end

    assign duty_1  = duty_a[0];
    assign duty_2  = duty_a[1];
    assign duty_3  = duty_a[2];
    assign duty_4  = duty_a[3];
    assign phase_1 = phase_a[0];
    assign phase_2 = phase_a[1];
    assign phase_3 = phase_a[2];
    assign phase_4 = phase_a[3];

endmodule

// File: tb/tb_shutter_actuation_seq.sv
// Directed bench for shutter_actuation_seq with CLK_PER_TICK=10, DEAD_CYCLES=4.
module tb_shutter_actuation_seq;
    import shutter_actuation_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] spi_cmd_r;
    logic [7:0]  spi_addr_r;
    logic [39:0] spi_data_r;
    logic        spi_data_valid_r;
    logic        em_stop;
    logic [11:0] duty_1, duty_2, duty_3, duty_4;
    logic        phase_1, phase_2, phase_3, phase_4;
    logic [3:0]  busy;

    int n_checks = 0;
    int n_errors = 0;

    shutter_actuation_seq #(
        .DEV_ID       (8'd0),
        .CLK_PER_TICK (10),
        .DUTY_WIDTH   (12),
        .TIME_WIDTH   (16),
        .DEAD_CYCLES  (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .spi_cmd_r        (spi_cmd_r),
        .spi_addr_r       (spi_addr_r),
        .spi_data_r       (spi_data_r),
        .spi_data_valid_r (spi_data_valid_r),
        .EM_STOP          (em_stop),
        .duty_1           (duty_1),
        .duty_2           (duty_2),
        .duty_3           (duty_3),
        .duty_4           (duty_4),
        .phase_1          (phase_1),
        .phase_2          (phase_2),
        .phase_3          (phase_3),
        .phase_4          (phase_4),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One-cycle strobe; returns on the negedge after the strobe edge.
    task automatic send(input logic [15:0] cmd, input logic [7:0] addr, input logic [39:0] data);
        @(negedge clk);
        spi_cmd_r        = cmd;
        spi_addr_r       = addr;
        spi_data_r       = data;
        spi_data_valid_r = 1'b1;
        @(negedge clk);
        spi_data_valid_r = 1'b0;
        spi_cmd_r        = '0;
        spi_data_r       = '0;
    endtask

    function automatic logic [39:0] cfg_word(input int ch, input int val);
        logic [39:0] w;
        w        = '0;
        w[17:16] = 2'(ch);
        w[15:0]  = 16'(val);
        return w;
    endfunction

    function automatic logic [39:0] mv_word(input int ch, input logic dir);
        logic [39:0] w;
        w      = '0;
        w[2:1] = 2'(ch);
        w[0]   = dir;
        return w;
    endfunction

    task automatic cfg_chan(input int ch, input int pd, input int hd, input int tm);
        send(C_SET_SHUTTER_PULSE_DUTY, 8'd0, cfg_word(ch, pd));
        send(C_SET_SHUTTER_HOLD_DUTY,  8'd0, cfg_word(ch, hd));
        send(C_SET_SHUTTER_PULSE_TIME, 8'd0, cfg_word(ch, tm));
    endtask

    initial begin
        reset            = 1'b1;
        em_stop          = 1'b0;
        spi_cmd_r        = '0;
        spi_addr_r       = '0;
        spi_data_r       = '0;
        spi_data_valid_r = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_duty_1", 32'(duty_1), 32'd0);
        check("reset_duty_4", 32'(duty_4), 32'd0);
        check("reset_phase",  32'({phase_1, phase_2, phase_3, phase_4}), 32'd0);
        check("reset_busy",   32'(busy), 32'd0);

        // 1: ch1 kick 50 clks then hold
        cfg_chan(0, 1800, 300, 5);
        send(C_SHUTTER_MOVE, 8'd0, mv_word(0, 1'b1));
        check("t1_first_duty",  32'(duty_1), 32'd1800);
        check("t1_first_phase", 32'(phase_1), 32'd1);
        check("t1_first_busy",  32'(busy[0]), 32'd1);
        repeat (49) @(negedge clk);
        check("t1_last_pulse_duty", 32'(duty_1), 32'd1800);
        check("t1_last_pulse_busy", 32'(busy[0]), 32'd1);
        @(negedge clk);
        check("t1_hold_duty", 32'(duty_1), 32'd300);
        check("t1_hold_busy", 32'(busy[0]), 32'd0);

        // 2: ch2 into HOLD dir=0, live hold write, then reverse through dead time
        cfg_chan(1, 1000, 200, 1);
        send(C_SHUTTER_MOVE, 8'd0, mv_word(1, 1'b0));
        check("t2_pulse_duty", 32'(duty_2), 32'd1000);
        repeat (12) @(negedge clk);
        check("t2_hold_duty",  32'(duty_2), 32'd200);
        send(C_SET_SHUTTER_HOLD_DUTY, 8'd0, cfg_word(1, 250));
        check("t2_live_hold",  32'(duty_2), 32'd250);
        send(C_SHUTTER_MOVE, 8'd0, mv_word(1, 1'b1));
        check("t2_dead_duty",  32'(duty_2), 32'd0);
        check("t2_dead_phase", 32'(phase_2), 32'd0);
        check("t2_dead_busy",  32'(busy[1]), 32'd1);
        repeat (3) @(negedge clk);
        check("t2_dead_end_duty",  32'(duty_2), 32'd0);
        check("t2_dead_end_phase", 32'(phase_2), 32'd0);
        @(negedge clk);
        check("t2_rev_duty",  32'(duty_2), 32'd1000);
        check("t2_rev_phase", 32'(phase_2), 32'd1);

        // 3: EM_STOP mid-pulse on ch3
        cfg_chan(2, 900, 100, 3);
        send(C_SHUTTER_MOVE, 8'd0, mv_word(2, 1'b0));
        repeat (5) @(negedge clk);
        check("t3_pulse_duty", 32'(duty_3), 32'd900);
        em_stop = 1'b1;
        @(negedge clk);
        check("t3_stop_duty3", 32'(duty_3), 32'd0);
        check("t3_stop_duty1", 32'(duty_1), 32'd0);
        check("t3_stop_busy",  32'(busy), 32'd0);
        send(C_SHUTTER_MOVE, 8'd0, mv_word(2, 1'b1));
        check("t3_move_ign_duty",  32'(duty_3), 32'd0);
        check("t3_move_ign_phase", 32'(phase_3), 32'd0);
        check("t3_move_ign_busy",  32'(busy), 32'd0);
        em_stop = 1'b0;
        repeat (2) @(negedge clk);
        check("t3_after_duty3", 32'(duty_3), 32'd0);
        check("t3_after_phase1", 32'(phase_1), 32'd1);

        // 4: ch4 zero ticks
        cfg_chan(3, 500, 0, 0);
        send(C_SHUTTER_MOVE, 8'd0, mv_word(3, 1'b1));
        check("t4_duty",  32'(duty_4), 32'd0);
        check("t4_busy",  32'(busy[3]), 32'd0);
        check("t4_phase", 32'(phase_4), 32'd1);
        repeat (2) @(negedge clk);
        check("t4_idle_duty", 32'(duty_4), 32'd0);
        send(C_SET_SHUTTER_HOLD_DUTY, 8'd0, cfg_word(3, 77));
        send(C_SHUTTER_MOVE, 8'd0, mv_word(3, 1'b1));
        check("t4_skip_to_hold", 32'(duty_4), 32'd77);
        check("t4_skip_busy",    32'(busy[3]), 32'd0);

        // 6: isolation - wrong address and release on another channel
        send(C_SHUTTER_MOVE, 8'd0, mv_word(0, 1'b1));
        check("t6_ch1_pulse", 32'(duty_1), 32'd1800);
        send(C_SHUTTER_MOVE, 8'd5, mv_word(0, 1'b0));
        check("t6_bad_addr_duty",  32'(duty_1), 32'd1800);
        check("t6_bad_addr_phase", 32'(phase_1), 32'd1);
        send(C_SET_SHUTTER_PULSE_DUTY, 8'd0, cfg_word(0, 1500));
        check("t6_live_pulse", 32'(duty_1), 32'd1500);
        send(C_SHUTTER_MOVE, 8'd0, mv_word(1, 1'b1));
        check("t6_ch2_pulse", 32'(duty_2), 32'd1000);
        send(C_SHUTTER_RELEASE, 8'd0, mv_word(1, 1'b0));
        check("t6_rel_duty2",  32'(duty_2), 32'd0);
        check("t6_rel_phase2", 32'(phase_2), 32'd1);
        check("t6_rel_busy",   32'(busy), 32'd1);
        check("t6_ch1_kept",   32'(duty_1), 32'd1500);

        // 5: async reset mid-pulse
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("t5_async_duty1", 32'(duty_1), 32'd0);
        check("t5_async_phase", 32'({phase_1, phase_2, phase_3, phase_4}), 32'd0);
        check("t5_async_busy",  32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_idle_duty1", 32'(duty_1), 32'd0);
        check("t5_idle_busy",  32'(busy), 32'd0);
        send(C_SHUTTER_MOVE, 8'd0, mv_word(0, 1'b1));
        check("t5_cfg_cleared_duty", 32'(duty_1), 32'd0);
        check("t5_cfg_cleared_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
